// File: rtl/pc_seq_ctrl_if.sv
// Instruction-fetch handshake between the next-PC sequencer (master) and
// instruction memory (slave).
interface pc_seq_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: picks trap > mret > branch > PC+4, owns the fetch handshake
// and parks redirects that arrive while a fetch is outstanding. Optional: PC_MISALIGN_TRAP_EN.
module pc_seq_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hazard_stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] mtvec,
  input  logic            halt_req,
  input  logic [XLEN-1:0] pc_cur,
  pc_seq_ctrl_if.master   imem,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_stall,
  output logic            if_flush,
  output logic            halted
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] redir_raw;
  logic [XLEN-1:0] redir_addr;
  logic            redirect;
  logic            imem_req;

  assign redirect = trap_req | mret_req | branch_taken;
  assign pc_seq   = pc_cur + XLEN'(4);

  always_comb begin
    if (trap_req)      redir_raw = mtvec;
    else if (mret_req) redir_raw = mepc;
    else               redir_raw = branch_target;
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign;
  // Only non-trap targets are checked; a bad target is swapped for mtvec.
  assign misalign   = !trap_req && redirect && (redir_raw[1:0] != 2'b00);
  assign redir_addr = misalign ? mtvec : redir_raw;
`else
  assign redir_addr = redir_raw;
`endif

  assign imem.imem_req  = imem_req;
  assign imem.imem_addr = pc_cur;

  always_comb begin
    imem_req = 1'b0;
    pc_stall = 1'b1;
    pc_next  = pc_seq;
    if_flush = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_exc = 1'b0;
`endif
    if (!rst) begin
      pc_next = RESET_VEC;
    end else begin
      case (state)
        BOOT: begin
          pc_stall = 1'b0;
          pc_next  = RESET_VEC;
        end
        FETCH: begin
          if (redirect) begin
            imem_req = 1'b1;
            if_flush = 1'b1;
            pc_next  = redir_addr;
            pc_stall = !imem.imem_ack;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_exc = misalign;
`endif
          end else if (!hazard_stall) begin
            imem_req = 1'b1;
            pc_stall = !imem.imem_ack;
          end
        end
        DRAIN: begin
          // A trap landing on the ack cycle bypasses the parked target.
          imem_req = 1'b1;
          pc_next  = trap_req ? mtvec : pend_target;
          if (imem.imem_ack) begin
            pc_stall = 1'b0;
            if_flush = 1'b1;
          end
        end
        HALT: begin
          if (trap_req) begin
            pc_stall = 1'b0;
            pc_next  = mtvec;
            if_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pend_target <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            if (!imem.imem_ack) begin
              pend_target <= redir_addr;
              state       <= DRAIN;
            end
          end else if (!hazard_stall && imem.imem_ack && halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        DRAIN: begin
          if (trap_req) pend_target <= mtvec;
          if (imem.imem_ack) state <= FETCH;
        end
        HALT: begin
          if (trap_req || !halt_req) begin
            state  <= FETCH;
            halted <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios then random traffic, all checked
// against a transaction-level model of the sequencer plus a PC register.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_stall, branch_taken, mret_req, trap_req, halt_req;
  logic [31:0] branch_target, mepc, mtvec;
  logic [31:0] pc_cur = 32'hDEAD_BEE0;
  logic [31:0] pc_next;
  logic        pc_stall, if_flush, halted;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  pc_seq_ctrl_if #(.XLEN(32)) imem_bus ();

  pc_seq_ctrl #(.XLEN(32), .RESET_VEC(RVEC)) dut (
    .clk           (clk),
    .rst           (rst),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mret_req      (mret_req),
    .mepc          (mepc),
    .trap_req      (trap_req),
    .mtvec         (mtvec),
    .halt_req      (halt_req),
    .pc_cur        (pc_cur),
    .imem          (imem_bus),
    .pc_next       (pc_next),
    .pc_stall      (pc_stall),
    .if_flush      (if_flush),
    .halted        (halted)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_exc  (misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  // PC register that the sequencer drives
  always @(posedge clk) if (!pc_stall) pc_cur <= pc_next;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: boot pending, parked redirect, halted, PC register
  bit          m_boot_due;
  bit          m_parked;
  logic [31:0] m_park_addr;
  bit          m_halted;
  logic [31:0] m_pc = 32'hDEAD_BEE0;

  task automatic step(input bit r, hz, br, mr, tr, hl, ack,
                      input logic [31:0] bt, me, mt);
    bit          e_req, e_stall, e_flush, e_mis, e_halted, chk_next, redir;
    logic [31:0] e_next, target;
    @(negedge clk);
    check("pc_cur", pc_cur, m_pc);
    rst = r; hazard_stall = hz; branch_taken = br; mret_req = mr; trap_req = tr;
    halt_req = hl; imem_bus.imem_ack = ack;
    branch_target = bt; mepc = me; mtvec = mt;
    #1;
    e_req = 0; e_stall = 1; e_flush = 0; e_mis = 0; chk_next = 0; e_next = '0;
    e_halted = m_halted;
    redir  = tr | mr | br;
    target = tr ? mt : (mr ? me : bt);
    if (!r) begin
      e_halted = 0; chk_next = 1; e_next = RVEC;
      m_boot_due = 1; m_parked = 0; m_halted = 0;
    end else if (m_boot_due) begin
      e_stall = 0; chk_next = 1; e_next = RVEC; m_boot_due = 0;
    end else if (m_halted) begin
      if (tr) begin
        e_stall = 0; e_flush = 1; chk_next = 1; e_next = mt; m_halted = 0;
      end else if (!hl) m_halted = 0;
    end else if (m_parked) begin
      e_req = 1;
      if (tr) m_park_addr = mt;
      if (ack) begin
        e_stall = 0; e_flush = 1; chk_next = 1; e_next = m_park_addr; m_parked = 0;
      end
    end else if (redir) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (!tr && target[1:0] != 2'b00) begin target = mt; e_mis = 1; end
`endif
      e_req = 1; e_flush = 1;
      if (ack) begin e_stall = 0; chk_next = 1; e_next = target; end
      else begin m_parked = 1; m_park_addr = target; end
    end else if (!hz) begin
      e_req = 1;
      if (ack) begin
        e_stall = 0; chk_next = 1; e_next = m_pc + 32'd4;
        if (hl) m_halted = 1;
      end
    end
    check("imem_req", imem_bus.imem_req, e_req);
    check("imem_addr", imem_bus.imem_addr, pc_cur);
    check("pc_stall", pc_stall, e_stall);
    check("if_flush", if_flush, e_flush);
    check("halted", halted, e_halted);
    if (chk_next) check("pc_next", pc_next, e_next);
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_exc", misalign_exc, e_mis);
`endif
    if (!e_stall) m_pc = e_next;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFC;
      1:       return $urandom;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic pc_after_edge(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    check(tag, pc_cur, exp);
  endtask

  initial begin
    rst = 1; hazard_stall = 0; branch_taken = 0; mret_req = 0; trap_req = 0;
    halt_req = 0; imem_bus.imem_ack = 0;
    branch_target = '0; mepc = '0; mtvec = '0;
    m_boot_due = 1; m_parked = 0; m_park_addr = '0; m_halted = 0;
    #1 rst = 0;

    // Reset, then boot with ack held high: PC walks 0x100, 0x104, 0x108
    step(0, 0,0,0,0,0, 1, 0, 0, 0);
    step(0, 0,0,0,0,0, 1, 0, 0, 0);
    step(1, 0,0,0,0,0, 1, 0, 0, 0);
    pc_after_edge("boot_pc", 32'h100);
    step(1, 0,0,0,0,0, 1, 0, 0, 0);
    step(1, 0,0,0,0,0, 1, 0, 0, 0);
    pc_after_edge("seq_pc", 32'h108);

    // Branch with ack withheld for three cycles
    step(1, 0,1,0,0,0, 0, 32'h2000, 0, 0);
    step(1, 0,0,0,0,0, 0, 0, 0, 0);
    step(1, 0,0,0,0,0, 0, 0, 0, 0);
    step(1, 0,0,0,0,0, 1, 0, 0, 0);
    pc_after_edge("drain_pc", 32'h2000);

    // All three redirect sources together: trap wins
    step(1, 0,1,1,1,0, 1, 32'h3000, 32'h40, 32'h80);
    pc_after_edge("prio_pc", 32'h80);

    // Hazard stall freezes the PC; hazard does not block a redirect
    step(1, 1,0,0,0,0, 1, 0, 0, 0);
    step(1, 1,0,0,0,0, 1, 0, 0, 0);
    step(1, 1,1,0,0,0, 1, 32'h500, 0, 0);
    pc_after_edge("hz_redir_pc", 32'h500);

    // PC+4 wraps to zero
    step(1, 0,1,0,0,0, 1, 32'hFFFF_FFFC, 0, 0);
    step(1, 0,0,0,0,0, 1, 0, 0, 0);
    pc_after_edge("wrap_pc", 32'h0);

    // Halt, trap out of halt, then reset in the middle of a drain
    step(1, 0,0,0,0,1, 1, 0, 0, 0);
    step(1, 0,0,0,0,1, 1, 0, 0, 0);
    step(1, 0,0,0,1,1, 0, 0, 0, 32'h80);
    pc_after_edge("halt_trap_pc", 32'h80);
    step(1, 0,1,0,0,0, 0, 32'h700, 0, 0);
    step(0, 0,0,0,0,0, 0, 0, 0, 0);
    step(1, 0,0,0,0,0, 1, 0, 0, 0);

`ifdef PC_MISALIGN_TRAP_EN
    step(1, 0,1,0,0,0, 1, 32'h2002, 0, 32'h80);
    pc_after_edge("misalign_pc", 32'h80);
    step(1, 0,0,0,0,0, 1, 0, 0, 32'h80);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
           pick_target(), pick_target(), $urandom & 32'hFFFF_FFFC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
